// File: rtl/robber_language_pkg.sv
// rtl/robber_language_pkg.sv - shared constants and FSM encoding for the robber_language arbiter
package robber_language_pkg;

    localparam int BYTE_W           = 8;
    localparam int CHAN_W           = 1;
    localparam int DRAIN_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_STREAM   = 3'd3,
        ST_DRAIN    = 3'd4
    } arb_state_e;

endpackage

// File: rtl/robber_language_rr_pick.sv
// rtl/robber_language_rr_pick.sv - combinational two-way round-robin picker
module robber_language_rr_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic grant_any_o,
    output logic grant_idx_o
);

    // On a tie the channel that did not win last time gets the core.
    always_comb begin
        grant_any_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            grant_idx_o = ~last_grant_i;
        end else begin
            grant_idx_o = req1_i;
        end
    end

endmodule

// File: rtl/robber_language_arbiter.sv
// rtl/robber_language_arbiter.sv - shares one robber_language core between two byte streams
module robber_language_arbiter
    import robber_language_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset_l,

    input  logic [BYTE_W-1:0] ch0_data,
    input  logic              ch0_valid,
    input  logic              ch0_last,
    input  logic              ch0_encdec,
    output logic              ch0_ready,

    input  logic [BYTE_W-1:0] ch1_data,
    input  logic              ch1_valid,
    input  logic              ch1_last,
    input  logic              ch1_encdec,
    output logic              ch1_ready,

    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_chan,
    output logic              done,
    output logic              done_chan,
    output logic              grant_valid,
    output logic              grant_chan,
    output logic              err_stray,

    output logic [BYTE_W-1:0] core_data_in,
    output logic              core_data_in_valid,
    output logic              core_init,
    output logic              core_encdec,
    input  logic              core_busy,
    input  logic [BYTE_W-1:0] core_data_out,
    input  logic              core_data_out_valid
);

    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    arb_state_e       state_q;
    logic             grant_valid_q;
    logic             grant_chan_q;
    logic             last_grant_q;
    logic             core_encdec_q;
    logic             core_init_q;
    logic             done_q;
    logic             done_chan_q;
    logic             err_stray_q;
    logic [CNT_W-1:0] cnt_q;

    logic              pick_any;
    logic              pick_idx;
    logic              streaming;
    logic              sel_valid;
    logic              sel_last;
    logic [BYTE_W-1:0] sel_data;
    logic              xfer;
    logic              drain_reload;

    robber_language_rr_pick u_rr_pick (
        .req0_i       (ch0_valid),
        .req1_i       (ch1_valid),
        .last_grant_i (last_grant_q),
        .grant_any_o  (pick_any),
        .grant_idx_o  (pick_idx)
    );

    // Steer the owning channel onto the core input with zero latency while streaming.
    always_comb begin
        streaming          = (state_q == ST_STREAM);
        sel_valid          = grant_chan_q ? ch1_valid : ch0_valid;
        sel_last           = grant_chan_q ? ch1_last  : ch0_last;
        sel_data           = grant_chan_q ? ch1_data  : ch0_data;
        core_data_in       = streaming ? sel_data : '0;
        core_data_in_valid = streaming & sel_valid & ~core_busy;
        ch0_ready          = streaming & ~grant_chan_q & ~core_busy;
        ch1_ready          = streaming &  grant_chan_q & ~core_busy;
        xfer               = core_data_in_valid;
        drain_reload       = core_busy | core_data_out_valid;
    end

    // Core output is passed through and tagged; bytes arriving with no owner are dropped.
    always_comb begin
        out_data  = core_data_out;
        out_valid = core_data_out_valid & grant_valid_q;
        out_chan  = grant_chan_q;
    end

    // Message-level FSM: arbitrate, init the core, stream, then wait out the idle window.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q       <= ST_IDLE;
            grant_valid_q <= 1'b0;
            grant_chan_q  <= 1'b0;
            last_grant_q  <= 1'b1;
            core_encdec_q <= 1'b0;
            core_init_q   <= 1'b0;
            done_q        <= 1'b0;
            done_chan_q   <= 1'b0;
            err_stray_q   <= 1'b0;
            cnt_q         <= '0;
        end else begin
            core_init_q <= 1'b0;
            done_q      <= 1'b0;
            if (core_data_out_valid && !grant_valid_q) begin
                err_stray_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_chan_q  <= pick_idx;
                        core_encdec_q <= pick_idx ? ch1_encdec : ch0_encdec;
                        grant_valid_q <= 1'b1;
                        core_init_q   <= 1'b1;
                        state_q       <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    state_q <= ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    if (!core_busy) begin
                        state_q <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (xfer && sel_last) begin
                        cnt_q   <= DRAIN_LOAD;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The cycle showing a zero count is the done cycle; release after it.
                    if (cnt_q == '0) begin
                        grant_valid_q <= 1'b0;
                        core_encdec_q <= 1'b0;
                        last_grant_q  <= grant_chan_q;
                        state_q       <= ST_IDLE;
                    end else if (drain_reload) begin
                        cnt_q <= DRAIN_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            done_q      <= 1'b1;
                            done_chan_q <= grant_chan_q;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_chan  = grant_chan_q;
    assign core_init   = core_init_q;
    assign core_encdec = core_encdec_q;
    assign done        = done_q;
    assign done_chan   = done_chan_q;
    assign err_stray   = err_stray_q;

endmodule

// File: tb/tb_robber_language_arbiter.sv
// tb/tb_robber_language_arbiter.sv - directed self-checking bench for robber_language_arbiter
module tb_robber_language_arbiter;

    logic       clk = 1'b0;
    logic       reset_l;
    logic [7:0] ch0_data, ch1_data;
    logic       ch0_valid, ch0_last, ch0_encdec, ch0_ready;
    logic       ch1_valid, ch1_last, ch1_encdec, ch1_ready;
    logic [7:0] out_data;
    logic       out_valid, out_chan, done, done_chan, grant_valid, grant_chan, err_stray;
    logic [7:0] core_data_in;
    logic       core_data_in_valid, core_init, core_encdec, core_busy;
    logic [7:0] core_data_out;
    logic       core_data_out_valid;

    robber_language_arbiter #(.DRAIN_CYCLES(4), .CNT_W(8)) dut (
        .clk                 (clk),
        .reset_l             (reset_l),
        .ch0_data            (ch0_data),
        .ch0_valid           (ch0_valid),
        .ch0_last            (ch0_last),
        .ch0_encdec          (ch0_encdec),
        .ch0_ready           (ch0_ready),
        .ch1_data            (ch1_data),
        .ch1_valid           (ch1_valid),
        .ch1_last            (ch1_last),
        .ch1_encdec          (ch1_encdec),
        .ch1_ready           (ch1_ready),
        .out_data            (out_data),
        .out_valid           (out_valid),
        .out_chan            (out_chan),
        .done                (done),
        .done_chan           (done_chan),
        .grant_valid         (grant_valid),
        .grant_chan          (grant_chan),
        .err_stray           (err_stray),
        .core_data_in        (core_data_in),
        .core_data_in_valid  (core_data_in_valid),
        .core_init           (core_init),
        .core_encdec         (core_encdec),
        .core_busy           (core_busy),
        .core_data_out       (core_data_out),
        .core_data_out_valid (core_data_out_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t_last = 0;
    int ch1_hi = 0;
    int busy_viol = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] xlog[$];
    logic [1:0] init_log[$];
    int         init_cyc[$];
    logic       done_log[$];
    int         done_cyc[$];
    logic [8:0] out_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        xlog.delete();
        init_log.delete();
        init_cyc.delete();
        done_log.delete();
        done_cyc.delete();
        out_log.delete();
        ch1_hi    = 0;
        busy_viol = 0;
    endtask

    // One clock: drive channel heads after the edge, observe at the falling edge.
    task automatic cycle();
        cyc++;
        ch0_valid = (q0.size() != 0);
        ch0_data  = ch0_valid ? q0[0][7:0] : 8'h00;
        ch0_last  = ch0_valid ? q0[0][8]   : 1'b0;
        ch1_valid = (q1.size() != 0);
        ch1_data  = ch1_valid ? q1[0][7:0] : 8'h00;
        ch1_last  = ch1_valid ? q1[0][8]   : 1'b0;
        @(negedge clk);
        if (core_init) begin
            init_log.push_back({grant_chan, core_encdec});
            init_cyc.push_back(cyc);
        end
        if (core_data_in_valid) begin
            xlog.push_back({grant_chan, core_data_in});
            t_last = cyc;
        end
        if (done) begin
            done_log.push_back(done_chan);
            done_cyc.push_back(cyc);
        end
        if (out_valid) out_log.push_back({out_chan, out_data});
        if (ch1_ready) ch1_hi++;
        if (core_busy && (ch0_ready || ch1_ready || core_data_in_valid)) busy_viol++;
        if (ch0_valid && ch0_ready) void'(q0.pop_front());
        if (ch1_valid && ch1_ready) void'(q1.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic run_done(input int n, input int budget, input string tag);
        int k = 0;
        while (done_log.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, done_log.size(), n);
    endtask

    task automatic run_log(input int n, input int budget, input string tag);
        int k = 0;
        while (xlog.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, xlog.size(), n);
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_l = 1'b1;
    endtask

    initial begin
        reset_l = 1'b0;
        ch0_data = 8'h00; ch0_valid = 1'b0; ch0_last = 1'b0; ch0_encdec = 1'b0;
        ch1_data = 8'h00; ch1_valid = 1'b0; ch1_last = 1'b0; ch1_encdec = 1'b0;
        core_busy = 1'b0; core_data_out = 8'h00; core_data_out_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_outs", {done, done_chan, grant_valid, grant_chan, err_stray, core_init,
                         core_encdec, core_data_in_valid, out_valid, out_chan, ch0_ready, ch1_ready}, 0);
        chk("rst_core_data_in", core_data_in, 0);
        reset_l = 1'b1;

        // ch0 two-byte encode message, no backpressure
        clr_log();
        ch0_encdec = 1'b1;
        q0 = '{9'h061, 9'h162};
        run_done(1, 60, "t1_done_cnt");
        chk("t1_init_cnt", init_log.size(), 1);
        if (init_log.size() == 1) chk("t1_init_enc", init_log[0], 2'b01);
        chk("t1_xfer_cnt", xlog.size(), 2);
        if (xlog.size() == 2) begin
            chk("t1_byte0", xlog[0], 9'h061);
            chk("t1_byte1", xlog[1], 9'h062);
        end
        chk("t1_ch1_ready", ch1_hi, 0);
        if (done_log.size() == 1) begin
            chk("t1_done_chan", done_log[0], 0);
            chk("t1_drain_lat", done_cyc[0] - t_last, 5);
        end
        chk("t1_released", {grant_valid, core_encdec}, 0);

        // simultaneous requests out of reset: ch0 then ch1, twice
        do_reset();
        clr_log();
        ch0_encdec = 1'b0;
        ch1_encdec = 1'b1;
        q0 = '{9'h141};
        q1 = '{9'h142};
        run_done(2, 100, "t2_done_cnt");
        if (done_log.size() == 2) begin
            chk("t2_order", {done_log[0], done_log[1]}, 2'b01);
            chk("t2_init_gap", init_cyc[1] - done_cyc[0], 2);
        end
        if (init_log.size() == 2) chk("t2_init_log", {init_log[0], init_log[1]}, 4'b0011);
        if (xlog.size() == 2) chk("t2_bytes", {xlog[0], xlog[1]}, {9'h041, 9'h142});
        clr_log();
        q0 = '{9'h143};
        q1 = '{9'h144};
        run_done(2, 100, "t2b_done_cnt");
        if (done_log.size() == 2) chk("t2b_order", {done_log[0], done_log[1]}, 2'b01);

        // core_busy for three cycles in the middle of a message
        clr_log();
        q0 = '{9'h010, 9'h011, 9'h012, 9'h113};
        run_log(2, 40, "t3_first_two");
        core_busy = 1'b1;
        repeat (3) cycle();
        chk("t3_busy_no_xfer", xlog.size(), 2);
        core_busy = 1'b0;
        run_done(1, 60, "t3_done_cnt");
        chk("t3_busy_viol", busy_viol, 0);
        chk("t3_xfer_cnt", xlog.size(), 4);
        if (xlog.size() == 4)
            chk("t3_bytes", {xlog[0][7:0], xlog[1][7:0], xlog[2][7:0], xlog[3][7:0]}, 32'h10111213);

        // core output two cycles into the drain window restarts the count
        clr_log();
        q1 = '{9'h155};
        run_log(1, 40, "t4_xfer");
        cycle();
        cycle();
        core_data_out = 8'hA5;
        core_data_out_valid = 1'b1;
        cycle();
        core_data_out = 8'h00;
        core_data_out_valid = 1'b0;
        run_done(1, 60, "t4_done_cnt");
        if (done_log.size() == 1) begin
            chk("t4_done_chan", done_log[0], 1);
            chk("t4_drain_lat", done_cyc[0] - t_last, 8);
        end
        chk("t4_out_cnt", out_log.size(), 1);
        if (out_log.size() == 1) chk("t4_out_tag", out_log[0], 9'h1A5);
        chk("t4_no_stray", err_stray, 0);

        // asynchronous reset in the middle of a ch0 message with ch1 waiting
        clr_log();
        ch0_encdec = 1'b1;
        ch1_encdec = 1'b0;
        q0 = '{9'h020, 9'h021, 9'h122};
        q1 = '{9'h130};
        run_log(1, 40, "t5_first");
        #2;
        reset_l = 1'b0;
        #1;
        chk("t5_async_outs", {grant_valid, grant_chan, core_encdec, core_init, core_data_in_valid,
                              ch0_ready, ch1_ready, done}, 0);
        q0.delete();
        cycle();
        cycle();
        reset_l = 1'b1;
        chk("t5_no_done", done_log.size(), 0);
        run_done(1, 60, "t5_done_cnt");
        if (done_log.size() == 1) chk("t5_done_chan", done_log[0], 1);
        if (init_log.size() == 2) chk("t5_regrant", init_log[1], 2'b10);
        if (xlog.size() == 2) chk("t5_bytes", {xlog[0], xlog[1]}, {9'h020, 9'h130});

        // stray core output while unowned
        clr_log();
        chk("t6_err_pre", err_stray, 0);
        core_data_out = 8'h77;
        core_data_out_valid = 1'b1;
        cycle();
        core_data_out_valid = 1'b0;
        core_data_out = 8'h00;
        cycle();
        cycle();
        chk("t6_outv", out_log.size(), 0);
        chk("t6_err_set", err_stray, 1);
        do_reset();
        chk("t6_err_clr", err_stray, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/robber_language_arbiter.md
Name: robber_language_arbiter

Overview:
Shares one robber_language core between two byte-stream requesters, one whole message at a time.
- Grants the core round-robin, issues the init pulse with the granted channel's encdec mode, and streams that channel's bytes into the core under core_busy backpressure.
- Tags the core's output bytes with the owning channel, then releases the core after an idle drain window.
- Sits between the host-side stream sources and the robber_language core.

Parameters:
DRAIN_CYCLES, 4, consecutive idle cycles (no core_busy, no core_data_out_valid) required after the last input byte before the grant is released; legal range 1..255.
CNT_W, 8, width of the drain counter; must hold DRAIN_CYCLES.

Ports:
clk  in  1  clock
reset_l  in  1  reset, asynchronous, active-low
ch0_data  in  8  channel 0 input byte
ch0_valid  in  1  channel 0 byte present; also serves as channel 0's request
ch0_last  in  1  channel 0 byte is the final byte of its message
ch0_encdec  in  1  channel 0 mode (1 = encode, 0 = decode); sampled at grant
ch0_ready  out  1  channel 0 byte accepted this cycle when ch0_valid is also high
ch1_data, ch1_valid, ch1_last, ch1_encdec, ch1_ready  same as channel 0, for channel 1
out_data  out  8  core output byte
out_valid  out  1  out_data valid
out_chan  out  1  channel owning out_data
done  out  1  one-cycle pulse when a message completes
done_chan  out  1  channel of the completed message; valid with done
grant_valid  out  1  core currently owned
grant_chan  out  1  current owner
err_stray  out  1  sticky flag: core produced output while the core was unowned
core_data_in  out  8  byte to core
core_data_in_valid  out  1  byte to core valid
core_init  out  1  core init pulse
core_encdec  out  1  core mode
core_busy  in  1  core cannot accept a byte
core_data_out  in  8  core output byte
core_data_out_valid  in  1  core output byte valid

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; drain counter 0.
  - last_grant register = 1, so channel 0 wins the first tie.
  - Reset mid-message aborts the message; no done is issued.
- States: IDLE, INIT, WAIT_RDY, STREAM, DRAIN; registered FSM.
- IDLE:
  - ch0_ready = ch1_ready = 0.
  - If any chN_valid: grant the requester; if both request, grant the channel != last_grant.
  - On grant: register grant_chan and mode = granted chN_encdec; set grant_valid = 1; go to INIT.
- INIT:
  - core_init = 1 for exactly this one cycle, with core_encdec = latched mode.
  - Next state WAIT_RDY unconditionally.
- WAIT_RDY: stay while core_busy = 1; go to STREAM on the first cycle core_busy = 0. Minimum dwell is one cycle.
- STREAM:
  - core_data_in = granted chN_data (combinational, zero latency).
  - core_data_in_valid = granted chN_valid & ~core_busy.
  - granted chN_ready = ~core_busy; the other channel's ready = 0.
  - A transfer is valid & ready. A transfer with chN_last = 1 moves to DRAIN.
  - Granted valid low: no transfer; stay in STREAM.
- DRAIN:
  - Counter loads DRAIN_CYCLES on entry.
  - Counter reloads on any cycle with core_busy or core_data_out_valid; otherwise decrements.
  - When the counter reaches 0: done = 1, done_chan = grant_chan, last_grant = grant_chan, grant_valid = 0, go to IDLE.
  - Both readys are 0 throughout DRAIN.
- core_encdec holds the latched mode from INIT until the grant is released, then returns to 0. chN_encdec changes mid-message are ignored.
- Output routing:
  - out_data = core_data_out.
  - out_valid = core_data_out_valid & grant_valid (combinational).
  - out_chan = grant_chan.
  - core_data_out_valid with grant_valid = 0: byte dropped and err_stray set; err_stray clears only on reset.
- Back-to-back requests: after done, IDLE re-arbitrates in the following cycle. The earliest next core_init is two cycles after done.
- No message-length limit; a non-terminating message holds the grant indefinitely (by design).

Decomposition:
- Package robber_language_pkg:
  - FSM state encodings.
  - BYTE_W = 8.
  - Channel index width (1).
  - Default DRAIN_CYCLES constant, shared with the core bench.
- One sub-module, robber_language_rr_pick: combinational 2-way round-robin picker.
  - Inputs: two request bits, last_grant.
  - Outputs: grant_any, grant_idx.

Test Plan:
- ch0 sends 0x61,0x62(last) with ch0_encdec = 1; core_busy held 0:
  - Expect core_init high exactly one cycle with core_encdec = 1.
  - Both bytes appear on core_data_in in order.
  - ch1_ready stays 0 throughout.
  - done with done_chan = 0 exactly DRAIN_CYCLES cycles after the last idle-triggering event.
- ch0 and ch1 request in the same cycle out of reset:
  - ch0 is granted first; ch1 is granted after ch0's done.
  - Repeat with both requesting: ch0 then ch1 again, i.e. alternation holds.
- Backpressure: core_busy = 1 for 3 cycles mid-STREAM:
  - ch0_ready = 0 and core_data_in_valid = 0 for those 3 cycles.
  - No byte lost or duplicated.
- Drain extension: core_data_out_valid pulses 2 cycles into DRAIN:
  - Counter reloads; done is delayed accordingly.
  - Each pulse appears on out_valid with out_chan equal to the owner.
- Reset asserted mid-STREAM:
  - Asynchronously, all outputs go to 0 and the FSM to IDLE; no done.
  - After release, the pending ch1 request is granted next.
- core_data_out_valid pulsed in IDLE: out_valid stays 0; err_stray rises and stays 1 until reset.
